// File: rtl/K005297_supbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : K005297_supbd_pkg
//  Purpose  : Shared state encoding, fault codes and rotation slot index for
//             the SUPBD length-counter sequencer and its helpers.
//  Revision : 1.0  initial release
// ============================================================================
package K005297_supbd_pkg;

  // One-hot sequencer states
  typedef enum logic [6:0] {
    ST_IDLE     = 7'b000_0001,
    ST_ARM      = 7'b000_0010,
    ST_START    = 7'b000_0100,
    ST_WAIT_ACT = 7'b000_1000,
    ST_ACTIVE   = 7'b001_0000,
    ST_DONE     = 7'b010_0000,
    ST_FAULT    = 7'b100_0000
  } state_t;

  // Fault codes reported on ERRCODE
  localparam logic [1:0] c_ERR_NONE  = 2'b00;
  localparam logic [1:0] c_ERR_NOACK = 2'b01;
  localparam logic [1:0] c_ERR_TMO   = 2'b10;
  localparam logic [1:0] c_ERR_ABORT = 2'b11;

  // Rotation slot at which a burst is launched
  localparam int unsigned c_PHASE19 = 19;

endpackage
`default_nettype wire

// File: rtl/K005297_rotwdt.sv
`default_nettype none
// ============================================================================
//  Module   : K005297_rotwdt
//  Purpose  : Rotation-count watchdog. Counts phase ticks while enabled and
//             flags the tick on which the count reaches LIMIT.
//  Revision : 1.0  initial release
// ============================================================================
module K005297_rotwdt #(
  parameter int unsigned LIMIT = 4   // rotations before terminal, 1..7
) (
  input  logic i_MCLK,
  input  logic i_RST,
  input  logic i_CE,     // clock enable (active high)
  input  logic i_CLR,    // hold counter at zero
  input  logic i_PH,     // qualifying phase seen this tick
  output logic o_TERM    // this tick completes LIMIT rotations
);

  localparam logic [2:0] c_LAST = 3'(LIMIT - 1);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  // Next count: clear dominates, otherwise saturating increment on phase
  always_comb begin
    cnt_d = cnt_q;
    if (i_CLR) begin
      cnt_d = '0;
    end else if (i_PH && (cnt_q != 3'd7)) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  // Counter register, advancing only on enabled ticks
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      cnt_q <= '0;
    end else if (i_CE) begin
      cnt_q <= cnt_d;
    end
  end

  assign o_TERM = i_CE & ~i_CLR & i_PH & (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/k005297_supbdseq.sv
`default_nettype none
// ============================================================================
//  Module   : k005297_supbdseq
//  Purpose  : SUPBD burst sequencer. Queues one request, launches the length
//             counter at rotation slot 19, supervises ack/active/timeout and
//             reports completion, length check and fault status.
//  Revision : 1.0  initial release
// ============================================================================
module k005297_supbdseq
  import K005297_supbd_pkg::*;
#(
  parameter int unsigned EXP_BITS  = 14,
  parameter int unsigned TMO_ROT   = 4,
  parameter int unsigned ACK_TICKS = 3
) (
  input  logic        i_MCLK,
  input  logic        i_RST,
  input  logic        i_CLK2M_PCEN_n,
  input  logic [19:0] i_ROT20_n,
  input  logic        i_SYS_RUN_FLAG,
  input  logic        i_SUPBD_REQ,
  input  logic        i_SUPBDLCNTR_CNT,
  input  logic        i_SUPBD_ACT_n,
  input  logic        i_SUPBD_END_n,
  output logic        o_SUPBD_START_n,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic        o_LEN_OK,
  output logic [7:0]  o_BITCNT,
  output logic        o_ERR,
  output logic [1:0]  o_ERRCODE,
  output logic        o_REQ_OVF
);

  localparam logic [7:0] c_ACK_LAST = 8'(ACK_TICKS - 1);
  localparam logic [7:0] c_EXP_BITS = 8'(EXP_BITS);

  logic w_tick;
  logic w_ph19;
  logic w_tmo;
  logic w_unused_in;

  state_t     state_q,   state_d;
  logic       pend_q,    pend_d;
  logic       ovf_q,     ovf_d;
  logic [7:0] bitcnt_q,  bitcnt_d;
  logic [7:0] ackcnt_q,  ackcnt_d;
  logic [1:0] code_q,    code_d;
  logic       start_n_q, start_n_d;
  logic       busy_q,    busy_d;
  logic       done_q,    done_d;
  logic       lenok_q,   lenok_d;
  logic       err_q,     err_d;
  logic [1:0] errcode_q, errcode_d;

  assign w_tick = ~i_CLK2M_PCEN_n;
  assign w_ph19 = ~i_ROT20_n[c_PHASE19];
  // END_n is status only; remaining phase bits are not needed here
  assign w_unused_in = ^{i_SUPBD_END_n, i_ROT20_n};

  // Rotation timer runs only while the counter reports active
  K005297_rotwdt #(
    .LIMIT (TMO_ROT)
  ) u_rotwdt (
    .i_MCLK (i_MCLK),
    .i_RST  (i_RST),
    .i_CE   (w_tick),
    .i_CLR  (state_q != ST_ACTIVE),
    .i_PH   (w_ph19),
    .o_TERM (w_tmo)
  );

  // Request queue, next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    bitcnt_d  = bitcnt_q;
    ackcnt_d  = ackcnt_q;
    code_d    = code_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    lenok_d   = lenok_q;
    errcode_d = errcode_q;

    // One-deep queue: a second request while one is waiting is an overflow
    if (!i_SYS_RUN_FLAG) begin
      pend_d = 1'b0;
    end else if ((state_q != ST_IDLE) && i_SUPBD_REQ) begin
      if (pend_q) begin
        ovf_d = 1'b1;
      end
      pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_SYS_RUN_FLAG && (i_SUPBD_REQ || pend_q)) begin
          state_d  = ST_ARM;
          pend_d   = 1'b0;
          ovf_d    = 1'b0;
          bitcnt_d = '0;
        end
      end
      ST_ARM: begin
        if (!i_SYS_RUN_FLAG) begin
          state_d = ST_FAULT;
          code_d  = c_ERR_ABORT;
        end else if (w_ph19) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d  = ST_WAIT_ACT;
        ackcnt_d = '0;
      end
      ST_WAIT_ACT: begin
        if (!i_SYS_RUN_FLAG) begin
          state_d = ST_FAULT;
          code_d  = c_ERR_ABORT;
        end else if (!i_SUPBD_ACT_n) begin
          state_d = ST_ACTIVE;
        end else if (ackcnt_q >= c_ACK_LAST) begin
          state_d = ST_FAULT;
          code_d  = c_ERR_NOACK;
        end else begin
          ackcnt_d = ackcnt_q + 8'd1;
        end
      end
      ST_ACTIVE: begin
        if (i_SUPBDLCNTR_CNT && (bitcnt_q != 8'hFF)) begin
          bitcnt_d = bitcnt_q + 8'd1;
        end
        // Abort outranks normal end, which outranks timeout
        if (i_SUPBD_ACT_n && !i_SYS_RUN_FLAG) begin
          state_d = ST_FAULT;
          code_d  = c_ERR_ABORT;
        end else if (i_SUPBD_ACT_n) begin
          state_d = ST_DONE;
        end else if (w_tmo) begin
          state_d = ST_FAULT;
          code_d  = c_ERR_TMO;
        end
      end
      ST_DONE: begin
        done_d    = 1'b1;
        lenok_d   = (bitcnt_q == c_EXP_BITS);
        errcode_d = c_ERR_NONE;
        state_d   = ST_IDLE;
      end
      ST_FAULT: begin
        err_d     = 1'b1;
        errcode_d = code_q;
        lenok_d   = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // START_n and BUSY track the state being entered, so they are flops
    start_n_d = (state_d != ST_START);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and output registers; reset acts on every edge, updates on ticks
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state_q   <= ST_IDLE;
      pend_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bitcnt_q  <= '0;
      ackcnt_q  <= '0;
      code_q    <= c_ERR_NONE;
      start_n_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lenok_q   <= 1'b0;
      err_q     <= 1'b0;
      errcode_q <= c_ERR_NONE;
    end else if (w_tick) begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      bitcnt_q  <= bitcnt_d;
      ackcnt_q  <= ackcnt_d;
      code_q    <= code_d;
      start_n_q <= start_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lenok_q   <= lenok_d;
      err_q     <= err_d;
      errcode_q <= errcode_d;
    end
  end

  assign o_SUPBD_START_n = start_n_q;
  assign o_BUSY          = busy_q;
  assign o_DONE          = done_q;
  assign o_LEN_OK        = lenok_q;
  assign o_BITCNT        = bitcnt_q;
  assign o_ERR           = err_q;
  assign o_ERRCODE       = errcode_q;
  assign o_REQ_OVF       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_k005297_supbdseq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_k005297_supbdseq
//  Purpose  : Self-checking bench for the SUPBD sequencer: directed scenarios
//             with literal expectations, then randomized traffic against a
//             behavioural model compared on every master clock.
//  Revision : 1.0  initial release
// ============================================================================
module tb_k005297_supbdseq;

  localparam int EXP_BITS  = 14;
  localparam int TMO_ROT   = 4;
  localparam int ACK_TICKS = 3;

  // Model burst phases
  localparam int M_IDLE = 0, M_ARM = 1, M_GO = 2, M_ACK = 3,
                 M_RUN = 4, M_FIN = 5, M_FLT = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcen_n = 1'b1;
  logic [19:0] rot20_n = '1;
  logic        run = 1'b1;
  logic        req = 1'b0;
  logic        cnt = 1'b0;
  logic        act_n = 1'b1;
  logic        end_n = 1'b1;

  logic        o_START_n, o_BUSY, o_DONE, o_LEN_OK, o_ERR, o_REQ_OVF;
  logic [7:0]  o_BITCNT;
  logic [1:0]  o_ERRCODE;

  int n_chk = 0;
  int n_fail = 0;

  k005297_supbdseq #(
    .EXP_BITS (EXP_BITS), .TMO_ROT (TMO_ROT), .ACK_TICKS (ACK_TICKS)
  ) dut (
    .i_MCLK           (clk),
    .i_RST            (rst),
    .i_CLK2M_PCEN_n   (pcen_n),
    .i_ROT20_n        (rot20_n),
    .i_SYS_RUN_FLAG   (run),
    .i_SUPBD_REQ      (req),
    .i_SUPBDLCNTR_CNT (cnt),
    .i_SUPBD_ACT_n    (act_n),
    .i_SUPBD_END_n    (end_n),
    .o_SUPBD_START_n  (o_START_n),
    .o_BUSY           (o_BUSY),
    .o_DONE           (o_DONE),
    .o_LEN_OK         (o_LEN_OK),
    .o_BITCNT         (o_BITCNT),
    .o_ERR            (o_ERR),
    .o_ERRCODE        (o_ERRCODE),
    .o_REQ_OVF        (o_REQ_OVF)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mode, m_bits, m_ackwait, m_rots, m_code, m_errcode;
  bit m_pend, m_ovf, m_start_n, m_busy, m_done, m_lenok, m_err;

  task automatic model_reset();
    m_mode = M_IDLE; m_bits = 0; m_ackwait = 0; m_rots = 0; m_code = 0;
    m_errcode = 0; m_pend = 0; m_ovf = 0; m_start_n = 1; m_busy = 0;
    m_done = 0; m_lenok = 0; m_err = 0;
  endtask

  task automatic model_step(input bit r_req, input bit r_run, input bit r_cnt,
                            input bit r_act_n, input bit r_ph19);
    int nm;
    bit pend_old;
    nm = m_mode;
    pend_old = m_pend;
    m_done = 0;
    m_err = 0;
    if (!r_run) m_pend = 0;
    else if (m_mode != M_IDLE && r_req) begin
      if (pend_old) m_ovf = 1;
      m_pend = 1;
    end
    case (m_mode)
      M_IDLE: if (r_run && (r_req || pend_old)) begin
        nm = M_ARM; m_pend = 0; m_ovf = 0; m_bits = 0;
      end
      M_ARM: begin
        if (!r_run) begin nm = M_FLT; m_code = 3; end
        else if (r_ph19) nm = M_GO;
      end
      M_GO: begin nm = M_ACK; m_ackwait = 0; end
      M_ACK: begin
        if (!r_run) begin nm = M_FLT; m_code = 3; end
        else if (!r_act_n) begin nm = M_RUN; m_rots = 0; end
        else begin
          m_ackwait++;
          if (m_ackwait == ACK_TICKS) begin nm = M_FLT; m_code = 1; end
        end
      end
      M_RUN: begin
        if (r_cnt && m_bits < 255) m_bits++;
        if (r_ph19) m_rots++;
        if (r_act_n && !r_run) begin nm = M_FLT; m_code = 3; end
        else if (r_act_n) nm = M_FIN;
        else if (m_rots == TMO_ROT) begin nm = M_FLT; m_code = 2; end
      end
      M_FIN: begin m_done = 1; m_lenok = (m_bits == EXP_BITS); m_errcode = 0; nm = M_IDLE; end
      M_FLT: begin m_err = 1; m_errcode = m_code; m_lenok = 0; nm = M_IDLE; end
      default: nm = M_IDLE;
    endcase
    m_mode = nm;
    m_start_n = (nm != M_GO);
    m_busy = (nm != M_IDLE);
  endtask

  // Single compare process: advance model on each edge, check outputs after
  always @(posedge clk) begin
    if (rst) model_reset();
    else if (!pcen_n) model_step(req, run, cnt, act_n, !rot20_n[19]);
    #1;
    chk("START_n", int'(o_START_n), int'(m_start_n));
    chk("BUSY",    int'(o_BUSY),    int'(m_busy));
    chk("DONE",    int'(o_DONE),    int'(m_done));
    chk("LEN_OK",  int'(o_LEN_OK),  int'(m_lenok));
    chk("BITCNT",  int'(o_BITCNT),  m_bits);
    chk("ERR",     int'(o_ERR),     int'(m_err));
    chk("ERRCODE", int'(o_ERRCODE), m_errcode);
    chk("REQ_OVF", int'(o_REQ_OVF), int'(m_ovf));
  end

  // ---------------- stimulus ----------------
  int phase = 0;
  int n_ticks = 0, n_starts = 0, n_done = 0, n_err = 0;
  int start_phase = -1, start_tick = 0, evt_tick = 0;
  bit req_pulse = 0, rnd_mode = 0;
  int cm_st = 0, cm_left = 0, cm_npulses = 0;
  bit cm_ack = 1, cm_release = 1;

  task automatic cm_cfg(input bit a, input int n, input bit r);
    cm_ack = a; cm_npulses = n; cm_release = r; cm_st = 0;
  endtask

  task automatic cm_new();
    cm_cfg($urandom_range(0, 7) != 0, int'($urandom_range(0, 20)),
           $urandom_range(0, 3) != 0);
  endtask

  // One 2 MHz tick: a disabled MCLK cycle carrying noise, then the tick
  task automatic tick_cycle();
    @(negedge clk);
    pcen_n = 1'b1;
    req = 1'($urandom_range(0, 1));
    cnt = 1'($urandom_range(0, 1));
    @(negedge clk);
    pcen_n = 1'b0;
    rot20_n = ~(20'd1 << phase);
    end_n = 1'b1;
    cnt = 1'b0;
    case (cm_st)
      0: begin act_n = 1'b1; if (!o_START_n && cm_ack) cm_st = 1; end
      1: begin act_n = 1'b0; cm_left = cm_npulses; cm_st = 2; end
      default: begin
        if (cm_left > 0) begin act_n = 1'b0; cnt = 1'b1; cm_left--; end
        else if (cm_release) begin act_n = 1'b1; end_n = 1'b0; cm_st = 0; end
        else act_n = 1'b0;
      end
    endcase
    req = req_pulse;
    req_pulse = 0;
    @(posedge clk);
    #2;
    n_ticks++;
    if (!o_START_n) begin n_starts++; start_phase = phase; start_tick = n_ticks; end
    if (o_DONE) n_done++;
    if (o_ERR) n_err++;
    if (o_DONE || o_ERR) evt_tick = n_ticks;
    phase = (phase + 1) % 20;
    if (rnd_mode && (o_DONE || o_ERR)) cm_new();
  endtask

  task automatic wait_event(input string nm, input int limit);
    int i;
    i = 0;
    do begin tick_cycle(); i++; end while (!(o_DONE || o_ERR) && i < limit);
    if (!(o_DONE || o_ERR)) chk({nm, "_event_timeout"}, 0, 1);
  endtask

  task automatic wait_start(input string nm, input int target);
    int i;
    i = 0;
    while (n_starts < target && i < 100) begin tick_cycle(); i++; end
    if (n_starts < target) chk({nm, "_start_timeout"}, n_starts, target);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pcen_n = 1'($urandom_range(0, 1));
    @(negedge clk);
    rst = 1'b0;
    cm_st = 0;
    act_n = 1'b1;
    if (rnd_mode) cm_new();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int ns0, nd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_START_n", o_START_n, 1); chk("rst_BUSY", o_BUSY, 0);
    chk("rst_DONE", o_DONE, 0);       chk("rst_LEN_OK", o_LEN_OK, 0);
    chk("rst_BITCNT", o_BITCNT, 0);   chk("rst_ERR", o_ERR, 0);
    chk("rst_ERRCODE", o_ERRCODE, 0); chk("rst_REQ_OVF", o_REQ_OVF, 0);

    // Normal burst, request at phase 3
    cm_cfg(1, 14, 1);
    while (phase != 3) tick_cycle();
    n_starts = 0;
    req_pulse = 1;
    wait_event("normal", 200);
    chk("normal_DONE", o_DONE, 1);     chk("normal_LEN_OK", o_LEN_OK, 1);
    chk("normal_BITCNT", o_BITCNT, 14); chk("normal_ERRCODE", o_ERRCODE, 0);
    chk("normal_BUSY", o_BUSY, 0);     chk("normal_starts", n_starts, 1);
    chk("normal_start_phase", start_phase, 19);

    // Short burst
    cm_cfg(1, 13, 1);
    req_pulse = 1;
    wait_event("short", 200);
    chk("short_DONE", o_DONE, 1); chk("short_LEN_OK", o_LEN_OK, 0);
    chk("short_BITCNT", o_BITCNT, 13);

    // No acknowledge
    cm_cfg(0, 0, 1);
    req_pulse = 1;
    wait_event("noack", 200);
    chk("noack_ERR", o_ERR, 1); chk("noack_ERRCODE", o_ERRCODE, 1);
    chk("noack_BUSY", o_BUSY, 0); chk("noack_DONE", o_DONE, 0);
    chk("noack_latency", evt_tick - start_tick, 5);

    // Rotation timeout
    cm_cfg(1, 3, 0);
    req_pulse = 1;
    wait_event("tmo", 400);
    chk("tmo_ERR", o_ERR, 1); chk("tmo_ERRCODE", o_ERRCODE, 2);
    chk("tmo_BITCNT", o_BITCNT, 3); chk("tmo_LEN_OK", o_LEN_OK, 0);
    chk("tmo_latency", evt_tick - start_tick, 81);

    // Abort: RUN dropped while active, then counter ends
    cm_cfg(1, 10, 1);
    ns0 = n_starts; nd0 = n_done;
    req_pulse = 1;
    wait_start("abort", ns0 + 1);
    repeat (5) tick_cycle();
    run = 1'b0;
    wait_event("abort", 100);
    chk("abort_ERR", o_ERR, 1); chk("abort_ERRCODE", o_ERRCODE, 3);
    chk("abort_no_done", n_done, nd0);
    run = 1'b1;
    tick_cycle();

    // Queue and overflow
    cm_cfg(1, 14, 1);
    n_starts = 0; n_done = 0;
    req_pulse = 1;
    wait_start("queue", 1);
    repeat (3) tick_cycle();
    repeat (3) begin req_pulse = 1; tick_cycle(); tick_cycle(); end
    chk("queue_REQ_OVF", o_REQ_OVF, 1);
    wait_event("queue1", 100);
    chk("queue1_DONE", o_DONE, 1); chk("queue1_ERRCODE", o_ERRCODE, 0);
    chk("queue1_LEN_OK", o_LEN_OK, 1);
    wait_event("queue2", 100);
    chk("queue2_DONE", o_DONE, 1); chk("queue2_starts", n_starts, 2);
    chk("queue2_REQ_OVF", o_REQ_OVF, 0);
    repeat (40) tick_cycle();
    chk("queue_no_third", n_starts, 2);

    // Reset in the middle of a burst
    cm_cfg(1, 14, 1);
    ns0 = n_starts;
    req_pulse = 1;
    wait_start("midrst", ns0 + 1);
    repeat (6) tick_cycle();
    req_pulse = 1; tick_cycle();
    req_pulse = 1; tick_cycle();
    chk("midrst_pre_BUSY", o_BUSY, 1); chk("midrst_pre_OVF", o_REQ_OVF, 1);
    @(negedge clk);
    rst = 1'b1;
    pcen_n = 1'b1;
    @(posedge clk);
    #2;
    chk("midrst_START_n", o_START_n, 1); chk("midrst_BUSY", o_BUSY, 0);
    chk("midrst_DONE", o_DONE, 0);       chk("midrst_LEN_OK", o_LEN_OK, 0);
    chk("midrst_BITCNT", o_BITCNT, 0);   chk("midrst_ERR", o_ERR, 0);
    chk("midrst_ERRCODE", o_ERRCODE, 0); chk("midrst_REQ_OVF", o_REQ_OVF, 0);
    @(negedge clk);
    rst = 1'b0;
    cm_cfg(1, 14, 1);
    repeat (4) tick_cycle();

    // Randomized traffic against the model
    rnd_mode = 1;
    cm_new();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 999) < 2) do_reset();
      else begin
        if ($urandom_range(0, 7) == 0) req_pulse = 1;
        if (run && $urandom_range(0, 149) == 0) run = 1'b0;
        else if (!run && $urandom_range(0, 3) == 0) run = 1'b1;
        tick_cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
